bt_pkt_tx: RTL and testbench

BT_PKT_TX -- requirements
Module: bt_pkt_tx

---
 rtl/bt_pkt_tx_if.sv | 27 ++
 rtl/bt_pkt_tx.sv | 116 +++++++++++
 tb/tb_bt_pkt_tx.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bt_pkt_tx_if.sv
// rtl/bt_pkt_tx_if.sv - payload handshake and serial output bundle for bt_pkt_tx
interface bt_pkt_tx_if;
    logic        pkt_val;
    logic [15:0] pkt_data;
    logic        pkt_rdy;
    logic        busy;
    logic        pkt_done;
    logic        txd_tx;

    modport master (
        output pkt_val,
        output pkt_data,
        input  pkt_rdy,
        input  busy,
        input  pkt_done,
        input  txd_tx
    );

    modport slave (
        input  pkt_val,
        input  pkt_data,
        output pkt_rdy,
        output busy,
        output pkt_done,
        output txd_tx
    );
endinterface

// File: rtl/bt_pkt_tx.sv
// rtl/bt_pkt_tx.sv - 16-bit payload to 4-byte UART 8N1 frame (A5, hi, lo, xor checksum)
module bt_pkt_tx #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_RATE = 100_000_000
) (
    input  logic         clk_tx,
    input  logic         rst_clk_tx_n,
    bt_pkt_tx_if.slave   bus
);
    localparam int             DIV      = CLOCK_RATE / BAUD_RATE;
    localparam int             CW       = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
    localparam logic [7:0]     SYNC     = 8'hA5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic [1:0]    byte_idx_q;
    logic [2:0]    bit_idx_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [15:0]   data_q;
    logic          txd_q;
    logic          rdy_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    cur_byte;
    logic          accept;
    logic          bit_end;

    assign accept  = rdy_q & bus.pkt_val;
    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        case (byte_idx_q)
            2'd0:    cur_byte = SYNC;
            2'd1:    cur_byte = data_q[15:8];
            2'd2:    cur_byte = data_q[7:0];
            default: cur_byte = SYNC ^ data_q[15:8] ^ data_q[7:0];
        endcase
    end

    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            txd_q      <= 1'b1;
            rdy_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    cnt_q <= '0;
                    if (accept) begin
                        data_q     <= bus.pkt_data;
                        state_q    <= START;
                        txd_q      <= 1'b0;
                        rdy_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        byte_idx_q <= '0;
                        bit_idx_q  <= '0;
                    end
                end
                START: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        txd_q     <= cur_byte[0];
                    end
                end
                DATA: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= cur_byte[bit_idx_q + 3'd1];
                        end
                    end
                end
                STOP: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        // Next start bit follows the stop bit directly, no idle gap.
                        if (byte_idx_q != 2'd3) begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            state_q    <= START;
                            txd_q      <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            rdy_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.txd_tx   = txd_q;
    assign bus.pkt_rdy  = rdy_q;
    assign bus.busy     = busy_q;
    assign bus.pkt_done = done_q;
endmodule

// File: tb/tb_bt_pkt_tx.sv
// tb/tb_bt_pkt_tx.sv - directed self-checking bench for bt_pkt_tx at DIV=16
module tb_bt_pkt_tx;
    logic clk_tx = 1'b0;
    logic rst_clk_tx_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    bt_pkt_tx_if bus ();

    bt_pkt_tx #(.BAUD_RATE(1), .CLOCK_RATE(16)) dut (
        .clk_tx       (clk_tx),
        .rst_clk_tx_n (rst_clk_tx_n),
        .bus          (bus)
    );

    always #5 clk_tx = ~clk_tx;

    // Data bit j of byte i is sampled mid-bit, 16 cycles per bit, 160 per byte.
    function automatic logic [31:0] decode(input logic [639:0] tr);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8; j++)
                r[(3 - i) * 8 + j] = tr[i * 160 + 16 * (j + 1) + 8];
        return r;
    endfunction

    task automatic do_accept(input logic [15:0] d, input bit hold);
        bus.pkt_val  = 1'b1;
        bus.pkt_data = d;
        @(negedge clk_tx);
        if (!hold) bus.pkt_val = 1'b0;
    endtask

    // Entered at the negedge of frame cycle 0; leaves at the negedge of cycle 639.
    task automatic record_frame(input bit toggle, output logic [639:0] tr, output int bad);
        bad = 0;
        for (int k = 0; k < 640; k++) begin
            if (k > 0) @(negedge clk_tx);
            tr[k] = bus.txd_tx;
            if (bus.pkt_rdy !== 1'b0 || bus.busy !== 1'b1 || bus.pkt_done !== 1'b0) bad++;
            if (toggle) begin
                bus.pkt_val  = (k < 639) ? k[1] : 1'b0;
                bus.pkt_data = 16'($urandom);
            end
        end
    endtask

    task automatic test_reset;
        bus.pkt_val  = 1'b0;
        bus.pkt_data = 16'h0000;
        #2 rst_clk_tx_n = 1'b0;
        #1;
        checks++;
        if (bus.txd_tx !== 1'b1 || bus.pkt_rdy !== 1'b1 || bus.busy !== 1'b0 || bus.pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: txd=%b rdy=%b busy=%b done=%b required 1 1 0 0",
                     bus.txd_tx, bus.pkt_rdy, bus.busy, bus.pkt_done);
        end
        repeat (3) @(negedge clk_tx);
        rst_clk_tx_n = 1'b1;
        @(negedge clk_tx);
        checks++;
        if (bus.txd_tx !== 1'b1 || bus.pkt_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_idle: txd=%b rdy=%b required 1 1", bus.txd_tx, bus.pkt_rdy);
        end
    endtask

    task automatic run_frame(input logic [15:0] d, input logic [31:0] exp, input string name);
        logic [639:0] tr;
        int bad;
        do_accept(d, 1'b0);
        checks++;
        if (bus.txd_tx !== 1'b0 || bus.pkt_rdy !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: txd=%b rdy=%b busy=%b required 0 0 1", name, bus.txd_tx, bus.pkt_rdy, bus.busy);
        end
        record_frame(1'b0, tr, bad);
        checks++;
        if (decode(tr) !== exp) begin
            errors++;
            $display("FAIL %s_bytes: got %h required %h", name, decode(tr), exp);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_busy_window: %0d bad cycles required 0", name, bad);
        end
        @(negedge clk_tx);
        checks++;
        if (bus.pkt_done !== 1'b1 || bus.pkt_rdy !== 1'b1 || bus.busy !== 1'b0 || bus.txd_tx !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_at_640: done=%b rdy=%b busy=%b txd=%b required 1 1 0 1",
                     name, bus.pkt_done, bus.pkt_rdy, bus.busy, bus.txd_tx);
        end
        @(negedge clk_tx);
        checks++;
        if (bus.pkt_done !== 1'b0 || bus.txd_tx !== 1'b1 || bus.pkt_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_one_cycle: done=%b txd=%b rdy=%b required 0 1 1",
                     name, bus.pkt_done, bus.txd_tx, bus.pkt_rdy);
        end
    endtask

    task automatic test_single;
        run_frame(16'h1234, 32'hA5123483, "single_1234");
    endtask

    task automatic test_patterns;
        run_frame(16'hFFFF, 32'hA5FFFFA5, "pat_ffff");
        run_frame(16'h0000, 32'hA50000A5, "pat_0000");
    endtask

    task automatic test_back_to_back;
        logic [639:0] tr;
        int bad;
        do_accept(16'h1234, 1'b1);
        record_frame(1'b0, tr, bad);
        checks++;
        if (decode(tr) !== 32'hA5123483 || bad != 0) begin
            errors++;
            $display("FAIL b2b_first: got %h bad=%0d required A5123483 bad=0", decode(tr), bad);
        end
        @(negedge clk_tx);
        checks++;
        if (bus.pkt_done !== 1'b1 || bus.pkt_rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: done=%b rdy=%b required 1 1", bus.pkt_done, bus.pkt_rdy);
        end
        bus.pkt_data = 16'hABCD;
        @(negedge clk_tx);
        bus.pkt_val = 1'b0;
        checks++;
        if (bus.txd_tx !== 1'b0 || bus.pkt_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_start: txd=%b rdy=%b required 0 0", bus.txd_tx, bus.pkt_rdy);
        end
        record_frame(1'b0, tr, bad);
        checks++;
        if (decode(tr) !== 32'hA5ABCDC3 || bad != 0) begin
            errors++;
            $display("FAIL b2b_second: got %h bad=%0d required A5ABCDC3 bad=0", decode(tr), bad);
        end
        repeat (2) @(negedge clk_tx);
        checks++;
        if (bus.txd_tx !== 1'b1 || bus.pkt_rdy !== 1'b1 || bus.pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_after: txd=%b rdy=%b done=%b required 1 1 0", bus.txd_tx, bus.pkt_rdy, bus.pkt_done);
        end
    endtask

    task automatic test_mid_frame;
        logic [639:0] tr;
        int bad;
        do_accept(16'h5A3C, 1'b0);
        record_frame(1'b1, tr, bad);
        checks++;
        if (decode(tr) !== 32'hA55A3CC3) begin
            errors++;
            $display("FAIL midframe_bytes: got %h required A55A3CC3", decode(tr));
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midframe_rdy_low: %0d bad cycles required 0", bad);
        end
        repeat (2) @(negedge clk_tx);
        checks++;
        if (bus.txd_tx !== 1'b1 || bus.pkt_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_no_extra_accept: txd=%b rdy=%b required 1 1", bus.txd_tx, bus.pkt_rdy);
        end
    endtask

    task automatic test_bit_timing;
        logic [639:0] tr;
        int bad;
        int misaligned;
        int stop_bad;
        do_accept(16'h55AA, 1'b0);
        record_frame(1'b0, tr, bad);
        misaligned = 0;
        stop_bad = 0;
        for (int k = 1; k < 640; k++)
            if (tr[k] != tr[k - 1] && (k % 16) != 0) misaligned++;
        for (int i = 0; i < 4; i++) begin
            for (int k = 144; k < 160; k++)
                if (tr[i * 160 + k] !== 1'b1) stop_bad++;
            if (i < 3 && tr[i * 160 + 160] !== 1'b0) stop_bad++;
        end
        checks++;
        if (misaligned != 0) begin
            errors++;
            $display("FAIL timing_alignment: %0d off-grid transitions required 0", misaligned);
        end
        checks++;
        if (stop_bad != 0) begin
            errors++;
            $display("FAIL timing_stop_bits: %0d bad stop samples required 0", stop_bad);
        end
        checks++;
        if (decode(tr) !== 32'hA555AA5A) begin
            errors++;
            $display("FAIL timing_bytes: got %h required A555AA5A", decode(tr));
        end
        repeat (2) @(negedge clk_tx);
    endtask

    task automatic test_reset_mid;
        logic [639:0] tr;
        int bad;
        do_accept(16'h1234, 1'b0);
        repeat (340) @(negedge clk_tx);
        checks++;
        if (bus.txd_tx !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pre: txd=%b required 0 (byte 2 bit 0)", bus.txd_tx);
        end
        #1 rst_clk_tx_n = 1'b0;
        #1;
        checks++;
        if (bus.txd_tx !== 1'b1 || bus.pkt_rdy !== 1'b1 || bus.busy !== 1'b0 || bus.pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_immediate: txd=%b rdy=%b busy=%b done=%b required 1 1 0 0",
                     bus.txd_tx, bus.pkt_rdy, bus.busy, bus.pkt_done);
        end
        repeat (2) @(negedge clk_tx);
        rst_clk_tx_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk_tx);
            if (bus.txd_tx !== 1'b1 || bus.pkt_rdy !== 1'b1 || bus.pkt_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid_no_residual: %0d bad cycles required 0", bad);
        end
        do_accept(16'h0000, 1'b0);
        checks++;
        if (bus.txd_tx !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_new_accept: txd=%b required 0", bus.txd_tx);
        end
        record_frame(1'b0, tr, bad);
        checks++;
        if (decode(tr) !== 32'hA50000A5) begin
            errors++;
            $display("FAIL rstmid_new_frame: got %h required A50000A5", decode(tr));
        end
        repeat (2) @(negedge clk_tx);
    endtask

    initial begin
        test_reset();
        test_single();
        test_patterns();
        test_back_to_back();
        test_mid_frame();
        test_bit_timing();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
